// File: rtl/core_inst_pkg.sv
// core_inst_pkg
//   Shared definitions for the core instruction sequencer and the core-side
//   instruction decode.
//   - Bit positions of every field in the 64-bit core instruction word.
//   - The idle instruction word: both SRAMs deselected, xmem held in read mode.
//   - The sequencer FSM state encoding.
package core_inst_pkg;

  localparam int LOAD       = 0;
  localparam int EXECUTE    = 1;
  localparam int L0_WR      = 2;
  localparam int L0_RD      = 3;
  localparam int IFIFO_RD   = 4;
  localparam int IFIFO_WR   = 5;
  localparam int OFIFO_RD   = 6;
  localparam int A_XMEM_LSB = 7;
  localparam int A_XMEM_W   = 11;
  localparam int WEN_XMEM   = 18;
  localparam int CEN_XMEM   = 19;
  localparam int A_PMEM_LSB = 20;
  localparam int A_PMEM_W   = 11;
  localparam int WEN_PMEM   = 31;
  localparam int CEN_PMEM   = 32;
  localparam int ACC        = 33;
  localparam int SFU_PASS   = 34;
  localparam int REN_PMEM   = 35;
  localparam int DEBUG      = 63;

  // CEN_pmem(32), CEN_xmem(19), WEN_xmem(18) high; everything else low.
  localparam logic [63:0] IDLE_WORD = 64'h0000_0001_000C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_KRST,
    S_WL0,
    S_WLD,
    S_GAP,
    S_EXEC,
    S_DRAIN,
    S_RDOUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/onij_addr_gen.sv
// onij_addr_gen
//   Tracks the input position (nx, ny) of the next OFIFO row and maps it to
//   the output-row address for the current kernel offset (kx, ky).
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     clr               clear nx/ny (start of a kij pass)
//     step              one OFIFO row popped; advance to the next nij
//     kx, ky            kernel offset of the current kij
//     valid             current nij lands inside the output map
//     addr              output row index oy*OUT_W+ox (meaningful when valid)
module onij_addr_gen #(
  parameter int IN_W = 6,
  parameter int K_W  = 3,
  parameter int CW   = $clog2(IN_W),
  parameter int AW   = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          step,
  input  logic [CW-1:0] kx,
  input  logic [CW-1:0] ky,
  output logic          valid,
  output logic [AW-1:0] addr
);

  localparam int            OUT_W   = IN_W - K_W + 1;
  localparam logic [CW-1:0] XY_LAST = CW'(IN_W - 1);
  localparam logic [CW-1:0] OUT_LIM = CW'(OUT_W);

  logic [CW-1:0] nx;
  logic [CW-1:0] ny;
  logic [CW-1:0] ox;
  logic [CW-1:0] oy;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      nx <= '0;
      ny <= '0;
    end else if (step) begin
      if (nx == XY_LAST) begin
        nx <= '0;
        // ny saturates so surplus pops cannot wrap back into the map
        if (ny != XY_LAST) ny <= ny + 1'b1;
      end else begin
        nx <= nx + 1'b1;
      end
    end
  end

  // Compare before subtracting so a negative offset never aliases into range.
  assign ox    = nx - kx;
  assign oy    = ny - ky;
  assign valid = (nx >= kx) && (ny >= ky) && (ox < OUT_LIM) && (oy < OUT_LIM);
  assign addr  = AW'(oy) * AW'(OUT_W) + AW'(ox);

endmodule

// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer
//   Generates the 64-bit core instruction stream for one full convolution:
//   per kernel index it resets the core, loads ROW weight words through L0
//   into the PE array, streams LEN_NIJ activations and accumulates every OFIFO
//   row into psum SRAM; finally it reads back the LEN_ONIJ output rows.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     start          begin a pass (honoured only while idle)
//     ofifo_valid    core OFIFO holds a complete row
//     inst           registered core instruction word
//     core_reset     registered reset to core array/L0/OFIFO
//     busy, done     pass in progress / one-cycle completion pulse
//     kij_idx        current kernel index
//     rd_valid       sfp_out holds psum row rd_idx this cycle
//     rd_idx         output row index qualified by rd_valid
module core_inst_sequencer
  import core_inst_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int IN_W     = 6,
  parameter int K_W      = 3,
  parameter int WGT_BASE = 1024,
  parameter int GAP_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [63:0] inst,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx,
  output logic        rd_valid,
  output logic [3:0]  rd_idx
);

  localparam int OUT_W    = IN_W - K_W + 1;
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K_W * K_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int CW       = $clog2(IN_W);

  localparam logic [7:0]    PH_RST_LEN   = 8'(GAP_CYC);
  localparam logic [7:0]    PH_KRST_LAST = 8'(GAP_CYC + 1);
  localparam logic [7:0]    PH_ROW       = 8'(ROW);
  localparam logic [7:0]    PH_WL0_LAST  = 8'(ROW + 1);
  localparam logic [7:0]    PH_WLD_LAST  = 8'(COL + ROW);
  localparam logic [7:0]    PH_GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic [7:0]    PH_EXEC_LAST = 8'(LEN_NIJ);
  localparam logic [7:0]    PH_RD_LAST   = 8'(LEN_ONIJ - 1);
  localparam logic [7:0]    NIJ_END      = 8'(LEN_NIJ);
  localparam logic [3:0]    KIJ_LAST     = 4'(LEN_KIJ - 1);
  localparam logic [CW-1:0] K_LAST       = CW'(K_W - 1);
  localparam logic [10:0]   WGT_BASE_A   = 11'(WGT_BASE);

  state_t        state, state_n;
  logic [7:0]    phase, phase_n;
  logic [3:0]    kij;
  logic [CW-1:0] kx, ky;
  logic [7:0]    nij_cnt;
  logic [63:0]   inst_n;
  logic          core_reset_n;
  logic          pop;
  logic          clr;
  logic          kij_adv;
  logic          pvalid;
  logic [10:0]   paddr;
  logic [10:0]   xaddr;
  logic          rd_valid_p0;
  logic [3:0]    rd_idx_p0;

  onij_addr_gen #(
    .IN_W (IN_W),
    .K_W  (K_W),
    .CW   (CW),
    .AW   (11)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .step  (pop),
    .kx    (kx),
    .ky    (ky),
    .valid (pvalid),
    .addr  (paddr)
  );

  assign xaddr   = WGT_BASE_A + 11'(kij) * 11'(ROW) + 11'(phase);
  assign kij_idx = kij;

  always_comb begin
    state_n      = state;
    phase_n      = phase + 8'd1;
    inst_n       = IDLE_WORD;
    core_reset_n = 1'b0;
    clr          = 1'b0;
    kij_adv      = 1'b0;
    inst_n[DEBUG]    = 1'b0;
    inst_n[REN_PMEM] = 1'b0;
    inst_n[WEN_XMEM] = 1'b1;
    inst_n[IFIFO_WR] = 1'b0;
    inst_n[IFIFO_RD] = 1'b0;

    // Rows are popped only while a pass still expects them; extra valid
    // cycles after the LEN_NIJ-th row are left in the OFIFO.
    pop = ((state == S_EXEC) || (state == S_DRAIN)) && ofifo_valid &&
          (nij_cnt < NIJ_END);
    if (pop) begin
      inst_n[OFIFO_RD] = 1'b1;
      inst_n[SFU_PASS] = (kij == 4'd0);
      inst_n[ACC]      = (kij != 4'd0);
      if (pvalid) begin
        inst_n[CEN_PMEM] = 1'b0;
        inst_n[WEN_PMEM] = 1'b1;
        inst_n[A_PMEM_LSB +: A_PMEM_W] = paddr;
      end
    end

    unique case (state)
      S_IDLE: begin
        phase_n = 8'd0;
        if (start) state_n = S_KRST;
      end
      S_KRST: begin
        core_reset_n = (phase < PH_RST_LEN);
        if (phase == PH_KRST_LAST) begin
          state_n = S_WL0;
          phase_n = 8'd0;
        end
      end
      S_WL0: begin
        // SRAM data lags the address by one cycle, so L0 writes run one
        // cycle past the last read.
        if (phase < PH_ROW) begin
          inst_n[CEN_XMEM] = 1'b0;
          inst_n[A_XMEM_LSB +: A_XMEM_W] = xaddr;
        end
        if (phase != 8'd0) inst_n[L0_WR] = 1'b1;
        if (phase == PH_WL0_LAST) begin
          state_n = S_WLD;
          phase_n = 8'd0;
        end
      end
      S_WLD: begin
        inst_n[L0_RD] = 1'b1;
        if (phase != 8'd0) inst_n[LOAD] = 1'b1;
        if (phase == PH_WLD_LAST) begin
          state_n = S_GAP;
          phase_n = 8'd0;
        end
      end
      S_GAP: begin
        if (phase == PH_GAP_LAST) begin
          state_n = S_EXEC;
          phase_n = 8'd0;
          clr     = 1'b1;
        end
      end
      S_EXEC: begin
        inst_n[CEN_XMEM] = 1'b0;
        inst_n[A_XMEM_LSB +: A_XMEM_W] = 11'(phase);
        inst_n[L0_RD] = 1'b1;
        if (phase == 8'd0) inst_n[L0_WR]   = 1'b1;
        else               inst_n[EXECUTE] = 1'b1;
        if (phase == PH_EXEC_LAST) begin
          state_n = S_DRAIN;
          phase_n = 8'd0;
        end
      end
      S_DRAIN: begin
        // phase holds at 0 while rows are outstanding, then counts the two
        // flush cycles.
        if (nij_cnt == NIJ_END) begin
          if (phase == 8'd1) begin
            phase_n = 8'd0;
            if (kij == KIJ_LAST) begin
              state_n = S_RDOUT;
            end else begin
              state_n = S_KRST;
              kij_adv = 1'b1;
            end
          end
        end else begin
          phase_n = 8'd0;
        end
      end
      S_RDOUT: begin
        inst_n[CEN_PMEM] = 1'b0;
        inst_n[WEN_PMEM] = 1'b0;
        inst_n[A_PMEM_LSB +: A_PMEM_W] = 11'(phase);
        if (phase == PH_RD_LAST) begin
          state_n = S_DONE;
          phase_n = 8'd0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        phase_n = 8'd0;
      end
      default: begin
        state_n = S_IDLE;
        phase_n = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 8'd0;
      kij         <= 4'd0;
      kx          <= '0;
      ky          <= '0;
      nij_cnt     <= 8'd0;
      inst        <= IDLE_WORD;
      core_reset  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_valid_p0 <= 1'b0;
      rd_idx_p0   <= 4'd0;
      rd_valid    <= 1'b0;
      rd_idx      <= 4'd0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      inst       <= inst_n;
      core_reset <= core_reset_n;
      done       <= (state == S_DONE);

      if ((state == S_IDLE) && start) begin
        busy <= 1'b1;
        kij  <= 4'd0;
        kx   <= '0;
        ky   <= '0;
      end else if (state == S_DONE) begin
        busy <= 1'b0;
      end

      if (kij_adv) begin
        kij <= kij + 4'd1;
        if (kx == K_LAST) begin
          kx <= '0;
          ky <= ky + 1'b1;
        end else begin
          kx <= kx + 1'b1;
        end
      end

      if (clr)      nij_cnt <= 8'd0;
      else if (pop) nij_cnt <= nij_cnt + 8'd1;

      // p0: read issued on inst; p1: psum row available on sfp_out
      rd_valid_p0 <= (state == S_RDOUT);
      if (state == S_RDOUT) rd_idx_p0 <= phase[3:0];
      rd_valid <= rd_valid_p0;
      rd_idx   <= rd_idx_p0;
    end
  end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb_core_inst_sequencer
//   Scoreboard bench: the stimulus process queues the expected OFIFO pops,
//   weight-read addresses and readout rows; a monitor on the falling edge
//   pops and compares whenever the sequencer issues the matching operation.
module tb_core_inst_sequencer;

  localparam logic [63:0] IDLE_W = 64'h0000_0001_000C_0000;

  typedef struct {
    int kij;
    bit wr;
    int addr;
  } pop_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [63:0] inst;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;
  logic        rd_valid;
  logic [3:0]  rd_idx;

  core_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .kij_idx     (kij_idx),
    .rd_valid    (rd_valid),
    .rd_idx      (rd_idx)
  );

  always #5 clk = ~clk;

  pop_t popq[$];
  int   wq[$];
  int   rdq[$];
  int   rvq[$];
  int   checks = 0;
  int   errors = 0;
  int   pop_total = 0;
  int   done_cnt = 0;
  int   pk[9];
  int   obs_wr[9][36];
  int   obs_addr[9][36];
  int   prev_rd_a = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic pop_t model(input int k, input int n);
    pop_t e;
    int   ox, oy;
    ox     = (n % 6) - (k % 3);
    oy     = (n / 6) - (k / 3);
    e.kij  = k;
    e.wr   = (ox >= 0) && (ox < 4) && (oy >= 0) && (oy < 4);
    e.addr = e.wr ? (oy * 4 + ox) : 0;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [63:0] w;
    pop_t        e;
    int          k;
    w = inst;
    if (w[6] === 1'b1) begin
      pop_total++;
      chk("pop_expected", popq.size() > 0, 1);
      if (popq.size() > 0) begin
        e = popq.pop_front();
        chk("pop_kij", kij_idx, e.kij);
        chk("pop_wr", !w[32], e.wr);
        if (e.wr) begin
          chk("pop_addr", w[30:20], e.addr);
          chk("pop_wen", w[31], 1);
          chk("pop_sfu", w[34], e.kij == 0);
          chk("pop_acc", w[33], e.kij != 0);
        end
      end
      k = kij_idx;
      if (k < 9) begin
        if (pk[k] < 36) begin
          obs_wr[k][pk[k]]   = !w[32];
          obs_addr[k][pk[k]] = w[30:20];
        end
        pk[k]++;
      end
    end
    if (w[19] === 1'b0 && w[17:7] >= 11'd1024) begin
      chk("wgt_expected", wq.size() > 0, 1);
      if (wq.size() > 0) chk("wgt_addr", w[17:7], wq.pop_front());
    end
    if (w[32] === 1'b0 && w[31] === 1'b0) begin
      chk("rdout_expected", rdq.size() > 0, 1);
      if (rdq.size() > 0) chk("rdout_addr", w[30:20], rdq.pop_front());
    end
    if (rd_valid === 1'b1) begin
      chk("rdv_expected", rvq.size() > 0, 1);
      if (rvq.size() > 0) chk("rd_idx", rd_idx, rvq.pop_front());
      chk("rd_lag", prev_rd_a, rd_idx);
    end
    if (done === 1'b1) done_cnt++;
    prev_rd_a = (w[32] === 1'b0 && w[31] === 1'b0) ? int'(w[30:20]) : -1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, bad, snap, wc;
    logic prev_busy;
    int   kij0_wr[16] = '{0, 1, 2, 3, 6, 7, 8, 9, 12, 13, 14, 15, 18, 19, 20, 21};
    int   kij4_no[9]  = '{0, 1, 2, 3, 4, 5, 6, 11, 35};

    for (int k = 0; k < 9; k++) begin
      pk[k] = 0;
      for (int j = 0; j < 36; j++) begin
        obs_wr[k][j]   = -1;
        obs_addr[k][j] = -1;
      end
    end

    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, IDLE_W);
    chk("rst_core_reset", core_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_kij", kij_idx, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_idx", rd_idx, 0);
    reset = 1'b0;

    // ---- full pass ----
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) wq.push_back(1024 + k * 8 + i);
      for (int j = 0; j < 36; j++) popq.push_back(model(k, j));
    end
    for (int i = 0; i < 16; i++) begin
      rdq.push_back(i);
      rvq.push_back(i);
    end

    @(negedge clk);
    start = 1'b1;
    ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;

    bad = 0;
    for (n = 0; n < 50 && core_reset !== 1'b1; n++) begin
      if (inst !== IDLE_W) bad++;
      @(negedge clk);
    end
    chk("idle_before_krst", bad, 0);
    chk("core_reset_seen", core_reset, 1);
    for (n = 0; n < 100 && core_reset === 1'b1; n++) @(negedge clk);
    chk("core_reset_len", n, 10);

    for (n = 0; n < 100 && inst[2] !== 1'b1; n++) @(negedge clk);
    for (n = 0; n < 100 && inst[2] === 1'b1; n++) @(negedge clk);
    chk("l0_wr_run", n, 9);

    // start while busy must not restart the pass
    for (n = 0; n < 3000 && kij_idx != 4'd3; n++) @(negedge clk);
    chk("reach_kij3", kij_idx, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // OFIFO stall in the middle of DRAIN at kij 5
    for (n = 0; n < 3000 && kij_idx != 4'd5; n++) @(negedge clk);
    chk("reach_kij5", kij_idx, 5);
    for (n = 0; n < 500 && inst[1] !== 1'b1; n++) @(negedge clk);
    chk("k5_exec_seen", inst[1], 1);
    ofifo_valid = 1'b0;
    for (n = 0; n < 200 && inst[1] === 1'b1; n++) @(negedge clk);
    chk("k5_exec_end", inst[1], 0);
    ofifo_valid = 1'b1;
    repeat (10) @(negedge clk);
    ofifo_valid = 1'b0;
    @(posedge clk);
    snap = pop_total;
    repeat (20) @(posedge clk);
    chk("stall_no_pop", pop_total, snap);
    @(negedge clk);
    chk("stall_kij", kij_idx, 5);
    chk("stall_core_reset", core_reset, 0);
    chk("stall_idle_word", inst, IDLE_W);
    ofifo_valid = 1'b1;

    prev_busy = busy;
    for (n = 0; n < 5000 && done !== 1'b1; n++) begin
      prev_busy = busy;
      @(negedge clk);
    end
    chk("done_seen", done, 1);
    chk("busy_with_done", busy, 0);
    chk("busy_before_done", prev_busy, 1);
    repeat (5) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("pops_left", popq.size(), 0);
    chk("wgt_left", wq.size(), 0);
    chk("rdout_left", rdq.size(), 0);
    chk("rdv_left", rvq.size(), 0);
    chk("pop_total", pop_total, 324);
    for (int k = 0; k < 9; k++) chk($sformatf("pops_kij%0d", k), pk[k], 36);
    chk("end_busy", busy, 0);
    chk("end_inst", inst, IDLE_W);

    wc = 0;
    for (int j = 0; j < 36; j++) if (obs_wr[0][j] == 1) wc++;
    chk("kij0_write_count", wc, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("kij0_wr_nij%0d", kij0_wr[i]), obs_wr[0][kij0_wr[i]], 1);
      chk($sformatf("kij0_addr_nij%0d", kij0_wr[i]), obs_addr[0][kij0_wr[i]], i);
    end
    chk("kij4_nij7_wr", obs_wr[4][7], 1);
    chk("kij4_nij7_addr", obs_addr[4][7], 0);
    chk("kij4_nij28_wr", obs_wr[4][28], 1);
    chk("kij4_nij28_addr", obs_addr[4][28], 15);
    for (int i = 0; i < 9; i++)
      chk($sformatf("kij4_discard_nij%0d", kij4_no[i]), obs_wr[4][kij4_no[i]], 0);

    // ---- reset in EXEC of kij 1 ----
    for (int k = 0; k < 9; k++) pk[k] = 0;
    for (int i = 0; i < 16; i++) wq.push_back(1024 + i);
    for (int j = 0; j < 36; j++) popq.push_back(model(0, j));
    @(negedge clk);
    start = 1'b1;
    ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 3000 && kij_idx != 4'd1; n++) @(negedge clk);
    chk("p2_reach_kij1", kij_idx, 1);
    ofifo_valid = 1'b0;
    for (n = 0; n < 500 && inst[1] !== 1'b1; n++) @(negedge clk);
    chk("p2_exec_seen", inst[1], 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("p2_restart_ignored", core_reset, 0);
    chk("p2_busy", busy, 1);
    chk("p2_kij", kij_idx, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_inst", inst, IDLE_W);
    chk("mid_rst_kij", kij_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_core_reset", core_reset, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    reset = 1'b0;
    ofifo_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_inst", inst, IDLE_W);
    chk("post_rst_busy", busy, 0);
    chk("p2_pops_left", popq.size(), 0);
    chk("p2_wgt_left", wq.size(), 0);
    chk("p2_kij0_pops", pk[0], 36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
